// File: rtl/fifo_mc_sync_if.sv
// Write/read bus of the multi-channel entry FIFO: tail unit writes and commit,
// head unit reads and pop, plus per-channel status.
interface fifo_mc_sync_if #(
  parameter int NUM_CH    = 4,
  parameter int CH_SZ     = 2,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4,
  parameter int UWIDTH    = 8
) ();
  logic [CH_SZ-1:0]               wch;
  logic                           we;
  logic [PTR_IN_SZ-1:0]           waddr_in;
  logic [UWIDTH-1:0]              wdata;
  logic                           winc;
  logic [CH_SZ-1:0]               rch;
  logic                           rinc;
  logic [PTR_IN_SZ-1:0]           raddr_in;
  logic [UWIDTH-1:0]              rdata;
  logic [NUM_CH-1:0]              wfull;
  logic [NUM_CH-1:0]              rempty;
  logic [NUM_CH*(PTR_SZ+1)-1:0]   count;
  logic [NUM_CH-1:0]              werr;
  logic [NUM_CH-1:0]              rerr;

  modport master (
    output wch, we, waddr_in, wdata, winc, rch, rinc, raddr_in,
    input  rdata, wfull, rempty, count, werr, rerr
  );

  modport slave (
    input  wch, we, waddr_in, wdata, winc, rch, rinc, raddr_in,
    output rdata, wfull, rempty, count, werr, rerr
  );
endinterface

// File: rtl/fifo_mc_sync.sv
// Single-clock multi-channel entry FIFO: NUM_CH queues of DEPTH entries sharing one memory.
// Define FIFO_MC_ERR_FLAGS_EN to get sticky per-channel overflow/underflow flags.
module fifo_mc_sync #(
  parameter int NUM_CH    = 4,
  parameter int CH_SZ     = 2,
  parameter int DEPTH     = 4,
  parameter int PTR_SZ    = 2,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4
) (
  input  logic           clk,
  input  logic           rst,
  fifo_mc_sync_if.slave  bus
);
  localparam int CNT_W   = PTR_SZ + 1;
  localparam int ENTRIES = NUM_CH * DEPTH;
  localparam logic [PTR_IN_SZ-1:0] LAST_UNIT = PTR_IN_SZ'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(DEPTH);

  logic [UWIDTH-1:0] mem [ENTRIES][WIDTH];

  logic [NUM_CH-1:0][PTR_SZ-1:0] head_vec;
  logic [NUM_CH-1:0][PTR_SZ-1:0] tail_vec;
  logic [NUM_CH-1:0]             full;
  logic [NUM_CH-1:0]             empty;
  logic [NUM_CH-1:0]             push_ok;
  logic [NUM_CH-1:0]             pop_ok;
  logic [UWIDTH-1:0]             rdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PTR_SZ-1:0] head_reg;
      logic [PTR_SZ-1:0] tail_reg;
      logic [CNT_W-1:0]  count_reg;

      assign full[gi]  = (count_reg == FULL_CNT);
      assign empty[gi] = (count_reg == '0);
      // A full channel still accepts a push when the same channel pops this cycle.
      assign pop_ok[gi]  = bus.rinc && (bus.rch == CH_SZ'(gi)) && !empty[gi];
      assign push_ok[gi] = bus.winc && (bus.wch == CH_SZ'(gi)) && (!full[gi] || pop_ok[gi]);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          head_reg  <= '0;
          tail_reg  <= '0;
          count_reg <= '0;
        end else begin
          if (push_ok[gi]) tail_reg <= tail_reg + 1'b1;
          if (pop_ok[gi])  head_reg <= head_reg + 1'b1;
          case ({push_ok[gi], pop_ok[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      assign head_vec[gi] = head_reg;
      assign tail_vec[gi] = tail_reg;
      assign bus.count[gi*CNT_W +: CNT_W] = count_reg;
    end
  endgenerate

  assign bus.wfull  = full;
  assign bus.rempty = empty;

  logic                        wr_ok;
  logic                        rd_ok;
  logic [CH_SZ+PTR_SZ-1:0]     wr_entry;
  logic [CH_SZ+PTR_SZ-1:0]     rd_entry;

  assign wr_ok    = bus.we && !full[bus.wch] && (bus.waddr_in <= LAST_UNIT);
  assign rd_ok    = !empty[bus.rch] && (bus.raddr_in <= LAST_UNIT);
  assign wr_entry = {bus.wch, tail_vec[bus.wch]};
  assign rd_entry = {bus.rch, head_vec[bus.rch]};

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_entry][bus.waddr_in] <= bus.wdata;
  end

  // Registered read sees pre-edge memory, so a same-cycle write returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_reg <= '0;
    else      rdata_reg <= rd_ok ? mem[rd_entry][bus.raddr_in] : '0;
  end

  assign bus.rdata = rdata_reg;

`ifdef FIFO_MC_ERR_FLAGS_EN
  logic [NUM_CH-1:0] werr_set;
  logic [NUM_CH-1:0] rerr_set;
  logic [NUM_CH-1:0] werr_reg;
  logic [NUM_CH-1:0] rerr_reg;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_err
      assign werr_set[gi] = ((bus.winc && (bus.wch == CH_SZ'(gi)) && !push_ok[gi]) ||
                             (bus.we   && (bus.wch == CH_SZ'(gi)) && full[gi]));
      assign rerr_set[gi] = bus.rinc && (bus.rch == CH_SZ'(gi)) && empty[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      werr_reg <= '0;
      rerr_reg <= '0;
    end else begin
      werr_reg <= werr_reg | werr_set;
      rerr_reg <= rerr_reg | rerr_set;
    end
  end

  assign bus.werr = werr_reg;
  assign bus.rerr = rerr_reg;
`else
  assign bus.werr = '0;
  assign bus.rerr = '0;
`endif

endmodule

// File: tb/tb_fifo_mc_sync.sv
// Directed scoreboard bench for fifo_mc_sync: the driver queues expected state per cycle,
// a negedge monitor pops and compares.
module tb_fifo_mc_sync;
  localparam int NUM_CH = 4, CH_SZ = 2, DEPTH = 4, PTR_SZ = 2;
  localparam int WIDTH = 11, UWIDTH = 8, PTR_IN_SZ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fifo_mc_sync_if #(.NUM_CH(NUM_CH), .CH_SZ(CH_SZ), .PTR_SZ(PTR_SZ),
                    .PTR_IN_SZ(PTR_IN_SZ), .UWIDTH(UWIDTH)) bus ();

  fifo_mc_sync #(.NUM_CH(NUM_CH), .CH_SZ(CH_SZ), .DEPTH(DEPTH), .PTR_SZ(PTR_SZ),
                 .WIDTH(WIDTH), .UWIDTH(UWIDTH), .PTR_IN_SZ(PTR_IN_SZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         at;
    bit         chk_rd;
    logic [7:0] rd;
    logic [11:0] cnt;
    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] werr;
    logic [3:0] rerr;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt [4] = '{0, 0, 0, 0};
  logic [3:0] exp_werr = 4'b0;
  logic [3:0] exp_rerr = 4'b0;

  function automatic exp_t mk(string name, int at, bit chk_rd, logic [7:0] rd);
    exp_t e;
    e.name = name; e.at = at; e.chk_rd = chk_rd; e.rd = rd;
    e.cnt = '0; e.full = '0; e.empty = '0;
    for (int c = 0; c < 4; c++) begin
      e.cnt[c*3 +: 3] = 3'(exp_cnt[c]);
      e.full[c]  = (exp_cnt[c] == DEPTH);
      e.empty[c] = (exp_cnt[c] == 0);
    end
    e.werr = exp_werr;
    e.rerr = exp_rerr;
    return e;
  endfunction

  task automatic idle();
    bus.wch = '0; bus.we = 1'b0; bus.waddr_in = '0; bus.wdata = '0; bus.winc = 1'b0;
    bus.rch = '0; bus.rinc = 1'b0; bus.raddr_in = '0;
  endtask

  // Expectation for the state right after the next rising edge.
  task automatic go(string name, bit chk_rd = 1'b0, logic [7:0] rd = 8'h00);
    sb.push_back(mk(name, cyc + 1, chk_rd, rd));
    @(posedge clk); #1;
    idle();
  endtask

  // Expectation for the current cycle (used while reset is asserted).
  task automatic chk_now(string name);
    sb.push_back(mk(name, cyc, 1'b1, 8'h00));
  endtask

  task automatic push(int ch, logic [7:0] tag);
    bus.we = 1'b1; bus.wch = 2'(ch); bus.waddr_in = '0; bus.wdata = tag; bus.winc = 1'b1;
  endtask

  task automatic pop(int ch);
    bus.rch = 2'(ch); bus.raddr_in = '0; bus.rinc = 1'b1;
  endtask

  task automatic cmp(string name, string fld, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s.missed: checked at cycle %0d, expected at cycle %0d", e.name, cyc, e.at);
    end
    while (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      cmp(e.name, "count",  32'(bus.count),  32'(e.cnt));
      cmp(e.name, "rempty", 32'(bus.rempty), 32'(e.empty));
      cmp(e.name, "wfull",  32'(bus.wfull),  32'(e.full));
      cmp(e.name, "werr",   32'(bus.werr),   32'(e.werr));
      cmp(e.name, "rerr",   32'(bus.rerr),   32'(e.rerr));
      if (e.chk_rd) cmp(e.name, "rdata", 32'(bus.rdata), 32'(e.rd));
      $display("[%0d] %s count=%h rempty=%b wfull=%b rdata=%h", cyc, e.name,
               bus.count, bus.rempty, bus.wfull, bus.rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_now("in_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    go("post_rst", 1'b1, 8'h00);

    // ch2: out-of-range unit write, build 11 units, commit together with the last unit
    bus.we = 1'b1; bus.wch = 2'd2; bus.waddr_in = 4'd11; bus.wdata = 8'hFF;
    go("ch2_oob_wr");
    for (int u = 0; u < WIDTH; u++) begin
      bus.we = 1'b1; bus.wch = 2'd2; bus.waddr_in = 4'(u); bus.wdata = 8'(8'h10 + u);
      if (u == WIDTH - 1) begin
        bus.winc = 1'b1;
        exp_cnt[2] = 1;
      end
      go($sformatf("ch2_u%0d", u));
    end
    bus.rch = 2'd2; bus.raddr_in = 4'd5;  go("ch2_rd5",  1'b1, 8'h15);
    bus.rch = 2'd2; bus.raddr_in = 4'd10; go("ch2_rd10", 1'b1, 8'h1A);
    bus.rch = 2'd2; bus.raddr_in = 4'd11; go("ch2_rd11", 1'b1, 8'h00);
    bus.rch = 2'd2; bus.raddr_in = 4'd15; go("ch2_rd15", 1'b1, 8'h00);
    pop(2); exp_cnt[2] = 0;               go("ch2_pop",  1'b1, 8'h10);
    bus.rch = 2'd2; bus.raddr_in = 4'd5;  go("ch2_rd_empty", 1'b1, 8'h00);

    // ch0: fill, overflow, partial drain, refill across the wrap, full drain
    for (int t = 1; t <= 4; t++) begin
      push(0, 8'(t)); exp_cnt[0] = t;
      go($sformatf("ch0_push%0d", t));
    end
    push(0, 8'h09);
`ifdef FIFO_MC_ERR_FLAGS_EN
    exp_werr[0] = 1'b1;
`endif
    go("ch0_overflow");
    pop(0); exp_cnt[0] = 3; go("ch0_pop_a", 1'b1, 8'h01);
    pop(0); exp_cnt[0] = 2; go("ch0_pop_b", 1'b1, 8'h02);
    push(0, 8'h05); exp_cnt[0] = 3; go("ch0_push5");
    push(0, 8'h06); exp_cnt[0] = 4; go("ch0_push6");
    pop(0); exp_cnt[0] = 3; go("ch0_pop_c", 1'b1, 8'h03);
    pop(0); exp_cnt[0] = 2; go("ch0_pop_d", 1'b1, 8'h04);
    pop(0); exp_cnt[0] = 1; go("ch0_pop_e", 1'b1, 8'h05);
    pop(0); exp_cnt[0] = 0; go("ch0_pop_f", 1'b1, 8'h06);

    // ch1: full with simultaneous push and pop; the new entry reuses the popped slot as-is
    for (int t = 1; t <= 4; t++) begin
      push(1, 8'(8'h20 + t)); exp_cnt[1] = t;
      go($sformatf("ch1_push%0d", t));
    end
    bus.winc = 1'b1; bus.wch = 2'd1; pop(1);
    go("ch1_full_pushpop", 1'b1, 8'h21);
    pop(1); exp_cnt[1] = 3; go("ch1_pop_a", 1'b1, 8'h22);
    pop(1); exp_cnt[1] = 2; go("ch1_pop_b", 1'b1, 8'h23);
    pop(1); exp_cnt[1] = 1; go("ch1_pop_c", 1'b1, 8'h24);
    pop(1); exp_cnt[1] = 0; go("ch1_pop_d", 1'b1, 8'h21);

    // ch3: pop on empty, then push+pop on empty
    pop(3);
`ifdef FIFO_MC_ERR_FLAGS_EN
    exp_rerr[3] = 1'b1;
`endif
    go("ch3_empty_pop", 1'b1, 8'h00);
    push(3, 8'h33); pop(3); exp_cnt[3] = 1;
    go("ch3_pushpop_empty", 1'b1, 8'h00);
    bus.rch = 2'd3; bus.raddr_in = 4'd0; go("ch3_rd0", 1'b1, 8'h33);

    // independence: push ch0 while popping ch3
    push(0, 8'h44); pop(3); exp_cnt[0] = 1; exp_cnt[3] = 0;
    go("ind_push0_pop3", 1'b1, 8'h33);
    bus.rch = 2'd0; bus.raddr_in = 4'd0; go("ind_rd0", 1'b1, 8'h44);

    // asynchronous reset in the middle of a push
    @(posedge clk); #1;
    push(0, 8'h55);
    rst = 1'b0;
    exp_cnt = '{0, 0, 0, 0};
    exp_werr = 4'b0;
    exp_rerr = 4'b0;
    chk_now("rst_async");
    @(posedge clk); #1;
    chk_now("rst_hold");
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    go("rst_release", 1'b1, 8'h00);
    push(0, 8'h66); exp_cnt[0] = 1; go("post_rst_push");
    bus.rch = 2'd0; bus.raddr_in = 4'd0; go("post_rst_rd", 1'b1, 8'h66);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
